// File: rtl/sonar_capture.sv
// rtl/sonar_capture.sv - multi-channel ping-pong sample capture buffer with latched echo trigger
module sonar_capture #(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_W     = 8,
    parameter int DEPTH        = 2048,
    parameter int THRESH       = 128,
    parameter int HOLDOFF      = 400,
    parameter int TRIG_DEFAULT = 400,
    parameter int TRIG_CH      = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         smp_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] smp_data,
    input  logic                         swap_req,
    input  logic                         rd_en,
    input  logic [CW-1:0]                rd_ch,
    input  logic [AW-1:0]                rd_addr,
    input  logic                         rd_align,
    output logic [SAMPLE_W-1:0]          rd_data,
    output logic                         rd_valid,
    output logic                         wr_bank,
    output logic                         full,
    output logic [AW-1:0]                trig_addr,
    output logic                         trig_found,
    output logic [7:0]                   drop_cnt
);
    localparam logic [AW-1:0] TRIG_DEF = AW'(TRIG_DEFAULT);

    typedef enum logic {FILL, FULL} state_t;

    state_t              state;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       trig_w;
    logic                found_w;
    logic [SAMPLE_W-1:0] prev;
    logic [SAMPLE_W-1:0] cur;
    logic                crossing;
    logic                accept;
    logic [AW-1:0]       eff_addr;
    logic [CW-1:0]       rd_ch_safe;

    logic [SAMPLE_W-1:0] mem [CHANNELS][2*DEPTH];

    assign cur      = smp_data[TRIG_CH*SAMPLE_W +: SAMPLE_W];
    assign crossing = (int'(prev) < THRESH) && (int'(cur) >= THRESH);
    assign accept   = (state == FILL) && smp_valid;
    // Alignment shifts the read so that TRIG_DEFAULT lands on the latched trigger.
    assign eff_addr   = rd_align ? (rd_addr + trig_addr - TRIG_DEF) : rd_addr;
    assign rd_ch_safe = (int'(rd_ch) < CHANNELS) ? rd_ch : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem[c][{wr_bank, wr_addr}] <= smp_data[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_ch_safe][{~wr_bank, eff_addr}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wr_addr    <= '0;
            wr_bank    <= 1'b0;
            prev       <= '0;
            trig_w     <= TRIG_DEF;
            found_w    <= 1'b0;
            full       <= 1'b0;
            trig_addr  <= TRIG_DEF;
            trig_found <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (smp_valid) begin
                        prev    <= cur;
                        wr_addr <= wr_addr + 1'b1;
                        if (crossing && (int'(wr_addr) > HOLDOFF) && !found_w) begin
                            trig_w  <= wr_addr;
                            found_w <= 1'b1;
                        end
                        if (wr_addr == '1) begin
                            state <= FULL;
                            full  <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (smp_valid && (drop_cnt != 8'hff)) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                    if (swap_req) begin
                        wr_bank    <= ~wr_bank;
                        trig_addr  <= trig_w;
                        trig_found <= found_w;
                        trig_w     <= TRIG_DEF;
                        found_w    <= 1'b0;
                        state      <= FILL;
                        full       <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sonar_capture.sv
// tb/tb_sonar_capture.sv - self-checking bench for sonar_capture
module tb_sonar_capture;
    localparam int D  = 16;
    localparam int HD = 4;
    localparam int TD = 4;
    localparam int TH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        swap_req;
    logic        rd_en;
    logic [0:0]  rd_ch;
    logic [3:0]  rd_addr;
    logic        rd_align;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        wr_bank;
    logic        full;
    logic [3:0]  trig_addr;
    logic        trig_found;
    logic [7:0]  drop_cnt;

    sonar_capture #(
        .CHANNELS(2), .SAMPLE_W(8), .DEPTH(D), .THRESH(TH),
        .HOLDOFF(HD), .TRIG_DEFAULT(TD), .TRIG_CH(0)
    ) dut (
        .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_data(smp_data),
        .swap_req(swap_req), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
        .rd_align(rd_align), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_bank(wr_bank), .full(full), .trig_addr(trig_addr),
        .trig_found(trig_found), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: per-bank sample store plus the frame being collected.
    logic [7:0] m_mem [2][2][D];
    bit         m_def [2][D];
    logic [7:0] m_f0 [D];
    int         m_len, m_drop, m_trig_out;
    bit         m_full, m_wr_bank, m_found_out, m_rd_known;
    logic [7:0] m_prev, m_pre, m_rd;

    typedef struct {
        logic       ch;
        logic [3:0] addr;
        logic       align;
        logic [7:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // First rising crossing beyond the holdoff in the completed frame.
    task automatic frame_trig(output int a, output bit f);
        logic [7:0] p;
        a = TD;
        f = 1'b0;
        for (int i = 0; i < D; i++) begin
            p = (i == 0) ? m_pre : m_f0[i-1];
            if (!f && p < TH && m_f0[i] >= TH && i > HD) begin
                a = i;
                f = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic sw,
                         input logic re, input logic ch, input logic [3:0] ad, input logic al);
        int  bank, eff;
        bit  was_full;
        smp_valid = v; smp_data = d; swap_req = sw;
        rd_en = re; rd_ch = ch; rd_addr = ad; rd_align = al;
        if (re) begin
            bank = m_wr_bank ? 0 : 1;
            eff  = al ? (int'(ad) + m_trig_out - TD + D) % D : int'(ad);
            m_rd_known = m_def[bank][eff];
            m_rd       = m_mem[ch][bank][eff];
        end
        was_full = m_full;
        if (!was_full && v) begin
            m_mem[0][m_wr_bank][m_len] = d[7:0];
            m_mem[1][m_wr_bank][m_len] = d[15:8];
            m_def[m_wr_bank][m_len]    = 1'b1;
            if (m_len == 0) m_pre = m_prev;
            m_f0[m_len] = d[7:0];
            m_prev      = d[7:0];
            m_len++;
            if (m_len == D) m_full = 1'b1;
        end else if (was_full && v && m_drop < 255) begin
            m_drop++;
        end
        if (was_full && sw) begin
            m_wr_bank = ~m_wr_bank;
            frame_trig(m_trig_out, m_found_out);
            m_full = 1'b0;
            m_len  = 0;
        end
        @(posedge clk);
        #1;
        check("rd_valid", 32'(rd_valid), 32'(re));
        if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
        check("wr_bank", 32'(wr_bank), 32'(m_wr_bank));
        check("full", 32'(full), 32'(m_full));
        check("trig_addr", 32'(trig_addr), 32'(m_trig_out));
        check("trig_found", 32'(trig_found), 32'(m_found_out));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        smp_valid = 1'b0; smp_data = '0; swap_req = 1'b0;
        rd_en = 1'b0; rd_ch = '0; rd_addr = '0; rd_align = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_full = 0; m_len = 0; m_wr_bank = 0; m_prev = '0; m_pre = '0;
        m_trig_out = TD; m_found_out = 0; m_drop = 0; m_rd = '0; m_rd_known = 1;
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'(TD));
        check("rst_trig_found", 32'(trig_found), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    endtask

    task automatic rand_cycle(input logic v, input logic [15:0] d, input logic sw);
        cycle(v, d, sw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [7:0] b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < D; a++) m_def[b][a] = 1'b0;

        tbl[0] = '{1'b0, 4'd7,  1'b0, 8'd200};
        tbl[1] = '{1'b0, 4'd4,  1'b1, 8'd200};
        tbl[2] = '{1'b0, 4'd14, 1'b1, 8'd0};
        tbl[3] = '{1'b1, 4'd14, 1'b1, 8'd51};
        tbl[4] = '{1'b1, 4'd3,  1'b0, 8'd53};
        tbl[5] = '{1'b1, 4'd0,  1'b1, 8'd53};
        tbl[6] = '{1'b0, 4'd2,  1'b0, 8'd200};
        tbl[7] = '{1'b1, 4'd12, 1'b1, 8'd65};

        do_reset();

        // Frame A: ramp, swap_req during fill and on the final write are ignored.
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, {8'(100 + i), 8'(i)}, (i == 5 || i == D - 1), 1'b0, 1'b0, 4'h0, 1'b0);
            if (i == 5) check("swap_in_fill_ignored", 32'(wr_bank), 32'd0);
        end
        check("full_after_16", 32'(full), 32'd1);
        check("coincident_swap_no_swap", 32'(wr_bank), 32'd0);
        idle();
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        check("swap_wr_bank", 32'(wr_bank), 32'd1);
        check("no_cross_trig_addr", 32'(trig_addr), 32'(TD));
        check("no_cross_found", 32'(trig_found), 32'd0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
        check("read_ch1_addr3", 32'(rd_data), 32'd103);

        // Frame B: pulses at 2, 7, 11; only 7 latches.
        for (int i = 0; i < D; i++) begin
            b0 = (i == 2 || i == 7 || i == 11) ? 8'd200 : 8'd0;
            cycle(1'b1, {8'(50 + i), b0}, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        end
        for (int i = 0; i < 300; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        check("overrun_sat", 32'(drop_cnt), 32'd255);
        cycle(1'b1, 16'hffff, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0);
        check("swap_cycle_read_old_bank", 32'(rd_data), 32'd7);
        check("trig_latched_addr", 32'(trig_addr), 32'd7);
        check("trig_latched_found", 32'(trig_found), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b1, tbl[i].ch, tbl[i].addr, tbl[i].align);
            check($sformatf("tbl_rd%0d", i), 32'(rd_data), 32'(tbl[i].exp));
        end
        idle();
        check("rd_data_hold", 32'(rd_data), 32'(tbl[7].exp));

        // Random frames against the model.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < D; i++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                    rand_cycle(1'b0, 16'h0, 1'($urandom_range(0, 1)));
                rand_cycle(1'b1, 16'($urandom), 1'($urandom_range(0, 3) == 0));
            end
            for (int g = 0; g < int'($urandom_range(0, 4)); g++)
                rand_cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
            rand_cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
            for (int g = 0; g < 4; g++) rand_cycle(1'b0, 16'h0, 1'b0);
        end

        // Reset mid-fill abandons the frame.
        for (int i = 0; i < 9; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        do_reset();
        for (int i = 0; i < D; i++) cycle(1'b1, {8'(20 + i), 8'(10 + i)}, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        check("post_reset_addr0", 32'(rd_data), 32'd10);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0);
        check("post_reset_ch1_addr8", 32'(rd_data), 32'd28);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
